// File: rtl/terminal_pkg.sv
// rtl/terminal_pkg.sv - shared constants, character codes and state encodings for the text terminal path
package terminal_pkg;

    localparam int DEFAULT_COLS       = 80;
    localparam int DEFAULT_ROWS       = 60;
    localparam int DEFAULT_ADDR_WIDTH = 13;

    localparam logic [7:0] CHAR_BLANK     = 8'h20;
    localparam logic [7:0] CHAR_PRINT_LO  = 8'h20;
    localparam logic [7:0] CHAR_PRINT_HI  = 8'h7E;
    localparam logic [7:0] CHAR_NEWLINE   = 8'h0A;
    localparam logic [7:0] CHAR_BACKSPACE = 8'hF7;
    localparam logic [7:0] CHAR_ESC       = 8'h03;
    localparam logic [7:0] CHAR_LEFT      = 8'hEB;
    localparam logic [7:0] CHAR_RIGHT     = 8'hF4;
    localparam logic [7:0] CHAR_UP        = 8'hF5;
    localparam logic [7:0] CHAR_DOWN      = 8'hF2;
    localparam logic [7:0] CHAR_INVALID   = 8'hFF;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DECODE,
        ST_WRITE,
        ST_MOVE,
        ST_CLEAR,
        ST_CLR_GAP,
        ST_GAP
    } state_t;

    typedef enum logic [3:0] {
        OP_NONE,
        OP_INC_WRAP,
        OP_DEC,
        OP_LEFT,
        OP_RIGHT,
        OP_UP,
        OP_DOWN,
        OP_NEWLINE,
        OP_HOME
    } cursor_op_t;

endpackage

// File: rtl/cursor_position.sv
// rtl/cursor_position.sv - row/col/linear-address cursor registers updated by one op per cycle
// The linear address tracks row*COLS+col incrementally; row_base holds row*COLS for newline.
module cursor_position
    import terminal_pkg::*;
#(
    parameter int COLS       = DEFAULT_COLS,
    parameter int ROWS       = DEFAULT_ROWS,
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  cursor_op_t            op,
    output logic [ADDR_WIDTH-1:0] addr
);

    localparam int CW = $clog2(COLS);
    localparam int RW = $clog2(ROWS);
    localparam logic [CW-1:0]         COL_LAST = CW'(COLS - 1);
    localparam logic [RW-1:0]         ROW_LAST = RW'(ROWS - 1);
    localparam logic [ADDR_WIDTH-1:0] ROW_STEP = ADDR_WIDTH'(COLS);
    localparam logic [ADDR_WIDTH-1:0] ONE      = ADDR_WIDTH'(1);

    logic [RW-1:0]         row;
    logic [CW-1:0]         col;
    logic [ADDR_WIDTH-1:0] row_base;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            row      <= '0;
            col      <= '0;
            row_base <= '0;
            addr     <= '0;
        end else begin
            case (op)
                OP_INC_WRAP: begin
                    if (col != COL_LAST) begin
                        col  <= col + CW'(1);
                        addr <= addr + ONE;
                    end else if (row != ROW_LAST) begin
                        col      <= '0;
                        row      <= row + RW'(1);
                        row_base <= row_base + ROW_STEP;
                        addr     <= addr + ONE;
                    end else begin
                        col      <= '0;
                        row      <= '0;
                        row_base <= '0;
                        addr     <= '0;
                    end
                end
                OP_DEC: begin
                    if (col != '0) begin
                        col  <= col - CW'(1);
                        addr <= addr - ONE;
                    end else if (row != '0) begin
                        col      <= COL_LAST;
                        row      <= row - RW'(1);
                        row_base <= row_base - ROW_STEP;
                        addr     <= addr - ONE;
                    end
                end
                OP_LEFT: begin
                    if (col != '0) begin
                        col  <= col - CW'(1);
                        addr <= addr - ONE;
                    end
                end
                OP_RIGHT: begin
                    if (col != COL_LAST) begin
                        col  <= col + CW'(1);
                        addr <= addr + ONE;
                    end
                end
                OP_UP: begin
                    if (row != '0) begin
                        row      <= row - RW'(1);
                        row_base <= row_base - ROW_STEP;
                        addr     <= addr - ROW_STEP;
                    end
                end
                OP_DOWN: begin
                    if (row != ROW_LAST) begin
                        row      <= row + RW'(1);
                        row_base <= row_base + ROW_STEP;
                        addr     <= addr + ROW_STEP;
                    end
                end
                OP_NEWLINE: begin
                    col <= '0;
                    if (row != ROW_LAST) begin
                        row      <= row + RW'(1);
                        row_base <= row_base + ROW_STEP;
                        addr     <= row_base + ROW_STEP;
                    end else begin
                        row      <= '0;
                        row_base <= '0;
                        addr     <= '0;
                    end
                end
                OP_HOME: begin
                    row      <= '0;
                    col      <= '0;
                    row_base <= '0;
                    addr     <= '0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/ascii_cursor_controller.sv
// rtl/ascii_cursor_controller.sv - pops keyboard ASCII, moves the cursor and drives terminal writes
// Cursor ops are applied on the write strobe (WRITE) or in MOVE, so the cursor changes once per character.
module ascii_cursor_controller
    import terminal_pkg::*;
#(
    parameter int         COLS       = DEFAULT_COLS,
    parameter int         ROWS       = DEFAULT_ROWS,
    parameter int         ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
    parameter logic [7:0] BLANK      = CHAR_BLANK
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  kb_ready,
    input  logic [7:0]            kb_ascii,
    output logic                  kb_next,
    input  logic                  vga_busy,
    output logic                  vga_cs,
    output logic [ADDR_WIDTH-1:0] vga_address,
    output logic [7:0]            vga_data,
    output logic [ADDR_WIDTH-1:0] cursor_addr,
    output logic                  clearing
);

    localparam logic [ADDR_WIDTH-1:0] LAST_CELL = ADDR_WIDTH'(COLS * ROWS - 1);

    state_t                state, state_next, dec_state;
    logic [7:0]            char_reg, wr_data, dec_data;
    logic [ADDR_WIDTH-1:0] wr_addr, clr_cnt, dec_addr;
    cursor_op_t            pend_op, dec_op, cur_op;

    cursor_position #(
        .COLS       (COLS),
        .ROWS       (ROWS),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_cursor (
        .clk  (clk),
        .rst  (rst),
        .op   (cur_op),
        .addr (cursor_addr)
    );

    always_comb begin
        dec_op    = OP_NONE;
        dec_state = ST_MOVE;
        dec_addr  = cursor_addr;
        dec_data  = char_reg;
        if (char_reg >= CHAR_PRINT_LO && char_reg <= CHAR_PRINT_HI) begin
            dec_op    = OP_INC_WRAP;
            dec_state = ST_WRITE;
        end else begin
            case (char_reg)
                CHAR_NEWLINE: dec_op = OP_NEWLINE;
                CHAR_BACKSPACE: begin
                    if (cursor_addr != '0) begin
                        dec_op    = OP_DEC;
                        dec_state = ST_WRITE;
                        dec_addr  = cursor_addr - ADDR_WIDTH'(1);
                        dec_data  = BLANK;
                    end
                end
                CHAR_LEFT:    dec_op = OP_LEFT;
                CHAR_RIGHT:   dec_op = OP_RIGHT;
                CHAR_UP:      dec_op = OP_UP;
                CHAR_DOWN:    dec_op = OP_DOWN;
                CHAR_ESC:     dec_state = ST_CLEAR;
                CHAR_INVALID: dec_op = OP_NONE;
                default:      dec_op = OP_NONE;
            endcase
        end
    end

    always_comb begin
        state_next = state;
        vga_cs     = 1'b0;
        cur_op     = OP_NONE;
        case (state)
            ST_IDLE:   if (kb_ready) state_next = ST_FETCH;
            ST_FETCH:  state_next = ST_DECODE;
            ST_DECODE: state_next = dec_state;
            ST_WRITE: begin
                if (!vga_busy) begin
                    vga_cs     = 1'b1;
                    cur_op     = pend_op;
                    state_next = ST_GAP;
                end
            end
            ST_MOVE: begin
                cur_op     = pend_op;
                state_next = ST_GAP;
            end
            ST_CLEAR: begin
                if (!vga_busy) begin
                    vga_cs = 1'b1;
                    if (clr_cnt == LAST_CELL) begin
                        cur_op     = OP_HOME;
                        state_next = ST_GAP;
                    end else begin
                        state_next = ST_CLR_GAP;
                    end
                end
            end
            ST_CLR_GAP: state_next = ST_CLEAR;
            ST_GAP:     state_next = ST_IDLE;
            default:    state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= ST_IDLE;
            char_reg <= '0;
            wr_addr  <= '0;
            wr_data  <= '0;
            pend_op  <= OP_NONE;
            clr_cnt  <= '0;
        end else begin
            state <= state_next;
            if (state == ST_IDLE && kb_ready) char_reg <= kb_ascii;
            if (state == ST_DECODE) begin
                wr_addr <= dec_addr;
                wr_data <= dec_data;
                pend_op <= dec_op;
                clr_cnt <= '0;
            end
            if (state == ST_CLEAR && !vga_busy) clr_cnt <= clr_cnt + ADDR_WIDTH'(1);
        end
    end

    // Head is sampled in the same cycle as the pop; reset gating keeps the strobe low while rst is held.
    assign kb_next     = rst && (state == ST_IDLE) && kb_ready;
    assign clearing    = (state == ST_CLEAR) || (state == ST_CLR_GAP);
    assign vga_address = clearing ? clr_cnt : wr_addr;
    assign vga_data    = clearing ? BLANK : wr_data;

endmodule

// File: tb/tb_ascii_cursor_controller.sv
// tb/tb_ascii_cursor_controller.sv - scoreboard bench with FIFO model and arithmetic cursor reference
module tb_ascii_cursor_controller;

    localparam int COLS  = 80;
    localparam int ROWS  = 60;
    localparam int AW    = 13;
    localparam int CELLS = COLS * ROWS;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          kb_ready = 1'b0;
    logic [7:0]    kb_ascii = 8'h00;
    logic          vga_busy = 1'b0;
    logic          kb_next, vga_cs, clearing;
    logic [AW-1:0] vga_address, cursor_addr;
    logic [7:0]    vga_data;

    ascii_cursor_controller #(
        .COLS       (COLS),
        .ROWS       (ROWS),
        .ADDR_WIDTH (AW),
        .BLANK      (8'h20)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .kb_ready    (kb_ready),
        .kb_ascii    (kb_ascii),
        .kb_next     (kb_next),
        .vga_busy    (vga_busy),
        .vga_cs      (vga_cs),
        .vga_address (vga_address),
        .vga_data    (vga_data),
        .cursor_addr (cursor_addr),
        .clearing    (clearing)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] addr;
        logic [7:0]    data;
        logic          clr;
    } wr_t;

    wr_t        exp_q[$];
    logic [7:0] fifo_q[$];
    int tests = 0, fails = 0;
    int pops = 0, sent = 0, strobes = 0;
    int busy_mode = 0;
    int mrow = 0, mcol = 0;
    logic pop_req = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
        end
    endtask

    // Keyboard FIFO model: head and ready change only just after a clock edge.
    always @(negedge clk) pop_req = kb_next;
    always @(posedge clk) begin
        #1;
        if (pop_req && fifo_q.size() > 0) begin
            void'(fifo_q.pop_front());
            pops++;
        end
        pop_req  = 1'b0;
        kb_ready = (fifo_q.size() != 0);
        if (kb_ready) kb_ascii = fifo_q[0];
        else          kb_ascii = 8'h00;
        case (busy_mode)
            0:       vga_busy = 1'b0;
            1:       vga_busy = ($urandom_range(0, 2) == 0);
            default: vga_busy = 1'b1;
        endcase
    end

    // Monitor: every strobe must match the oldest expected write.
    always @(negedge clk) begin
        wr_t e;
        if (kb_next) check("kb_next_while_ready", kb_ready, 1);
        if (vga_cs) begin
            strobes++;
            check("strobe_while_not_busy", vga_busy, 0);
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_strobe: got addr %0d data 0x%0h expected no write", vga_address, vga_data);
            end else begin
                e = exp_q.pop_front();
                check("write_addr", vga_address, e.addr);
                check("write_data", vga_data, e.data);
                check("write_clearing", clearing, e.clr);
            end
        end
    end

    task automatic model(input logic [7:0] c);
        int  a;
        wr_t e;
        a = mrow * COLS + mcol;
        if (c >= 8'h20 && c <= 8'h7E) begin
            e.addr = AW'(a); e.data = c; e.clr = 1'b0;
            exp_q.push_back(e);
            a = (a + 1) % CELLS;
            mrow = a / COLS; mcol = a % COLS;
        end else if (c == 8'h0A) begin
            mrow = (mrow + 1) % ROWS; mcol = 0;
        end else if (c == 8'hF7) begin
            if (a != 0) begin
                a = a - 1;
                mrow = a / COLS; mcol = a % COLS;
                e.addr = AW'(a); e.data = 8'h20; e.clr = 1'b0;
                exp_q.push_back(e);
            end
        end else if (c == 8'hEB) begin
            if (mcol > 0) mcol--;
        end else if (c == 8'hF4) begin
            if (mcol < COLS - 1) mcol++;
        end else if (c == 8'hF5) begin
            if (mrow > 0) mrow--;
        end else if (c == 8'hF2) begin
            if (mrow < ROWS - 1) mrow++;
        end else if (c == 8'h03) begin
            for (int i = 0; i < CELLS; i++) begin
                e.addr = AW'(i); e.data = 8'h20; e.clr = 1'b1;
                exp_q.push_back(e);
            end
            mrow = 0; mcol = 0;
        end
    endtask

    task automatic send(input logic [7:0] c, input int n);
        for (int i = 0; i < n; i++) begin
            model(c);
            fifo_q.push_back(c);
            sent++;
        end
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        while ((fifo_q.size() != 0 || pops != sent) && n < 2000) begin
            @(negedge clk); n++;
        end
        if (n >= 2000) check({name, "_pop_timeout"}, pops, sent);
        n = 0;
        while (exp_q.size() != 0 && n < 40000) begin
            @(negedge clk); n++;
        end
        if (n >= 40000) check({name, "_write_timeout"}, exp_q.size(), 0);
        repeat (6) @(negedge clk);
        check(name, cursor_addr, mrow * COLS + mcol);
    endtask

    initial begin
        #900us;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int s0;
        int k, r;
        logic [7:0] c;

        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_vga_cs", vga_cs, 0);
        check("reset_kb_next", kb_next, 0);
        check("reset_clearing", clearing, 0);
        check("reset_vga_address", vga_address, 0);
        check("reset_vga_data", vga_data, 0);
        check("reset_cursor", cursor_addr, 0);
        rst = 1'b1;
        @(negedge clk);

        send(8'h61, 1); send(8'h62, 1);
        wait_done("cursor_after_ab");
        check("pops_after_ab", pops, 2);

        send(8'hF4, 77);  wait_done("cursor_79");
        send(8'h0A, 1);   wait_done("newline_to_80");
        send(8'hF2, 59);  wait_done("down_to_last_row");
        send(8'hF4, 79);  wait_done("cursor_4799");
        send(8'h78, 1);   wait_done("wrap_to_0");
        send(8'hF2, 1);   wait_done("cursor_80");
        send(8'hF7, 1);   wait_done("backspace_to_79");
        send(8'hF5, 1); send(8'hEB, 79); wait_done("back_to_0");
        s0 = strobes;
        send(8'hF7, 1);   wait_done("backspace_at_home");
        send(8'hF5, 1); send(8'hEB, 1); wait_done("up_left_clamped");
        check("no_write_on_moves", strobes, s0);
        send(8'hF2, 1); send(8'hF4, 1); wait_done("down_right_81");

        busy_mode = 2;
        s0 = strobes;
        send(8'h51, 1);
        repeat (6) @(negedge clk);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("busy_no_strobe", vga_cs, 0);
            check("busy_addr_stable", vga_address, 81);
            check("busy_data_stable", vga_data, 8'h51);
        end
        busy_mode = 0;
        wait_done("after_busy");
        check("single_strobe_after_busy", strobes - s0, 1);

        busy_mode = 1;
        for (int i = 0; i < 150; i++) begin
            k = $urandom_range(0, 9);
            case (k)
                0, 1, 2, 3, 4: c = 8'($urandom_range(32, 126));
                5: c = 8'h0A;
                6: c = 8'hF7;
                7: begin
                    r = $urandom_range(0, 3);
                    c = (r == 0) ? 8'hEB : (r == 1) ? 8'hF4 : (r == 2) ? 8'hF5 : 8'hF2;
                end
                8: c = 8'hFF;
                default: begin
                    c = 8'($urandom_range(0, 255));
                    if (c == 8'h03) c = 8'hFF;
                end
            endcase
            send(c, 1);
            wait_done("random_cursor");
        end

        s0 = strobes;
        send(8'h03, 1);
        wait_done("clear_cursor_home");
        check("clear_strobe_count", strobes - s0, CELLS);
        check("clearing_low_after", clearing, 0);

        busy_mode = 0;
        send(8'h41, 1); wait_done("write_before_abort");
        s0 = strobes;
        send(8'h03, 1);
        for (int i = 0; i < 1000; i++) begin
            @(posedge clk); #2;
            if (strobes - s0 >= 100) break;
        end
        check("abort_reached_100", strobes - s0, 100);
        rst = 1'b0;
        #1;
        check("abort_vga_cs", vga_cs, 0);
        check("abort_clearing", clearing, 0);
        check("abort_vga_address", vga_address, 0);
        check("abort_vga_data", vga_data, 0);
        check("abort_cursor", cursor_addr, 0);
        check("abort_kb_next", kb_next, 0);
        exp_q.delete();
        mrow = 0; mcol = 0;
        s0 = strobes;
        repeat (30) @(negedge clk);
        rst = 1'b1;
        repeat (10) @(negedge clk);
        check("no_strobes_after_abort", strobes, s0);
        send(8'h7A, 1); wait_done("recover_after_abort");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
